alu: RTL and testbench

//   32-bit integer ALU for the single-cycle MIPS datapath (execute stage).
//   - Combinational result and zero flag: same-cycle branch compare and address/data compute.
//   - Also presents a one-cycle registered copy of result and flags for a pipelined consumer.
//   - Opcode encoding follows the standard MIPS ALU-control table.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_addsub.sv | 35 +++
 rtl/alu.sv | 101 ++++++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the MIPS execute-stage ALU and its ALU-control decoder.
//   Contents:
//     ALU_WIDTH          default datapath width
//     ALU_AND .. ALU_NOR 4-bit operation codes (standard MIPS ALU-control table)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Codes that run the shared adder in subtract mode.
    function automatic logic is_subtract(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
//   Single WIDTH-bit adder shared by ADD, SUB and SLT. Subtract is done by
//   inverting operand B and injecting a carry-in of 1 (two's complement).
//   Ports:
//     a_i    in  WIDTH  operand A
//     b_i    in  WIDTH  operand B
//     sub_i  in  1      1 = a - b, 0 = a + b
//     sum_o  out WIDTH  result modulo 2^WIDTH (carry/borrow discarded)
//     ovf_o  out 1      signed overflow of the selected operation
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin;

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        cin   = {{(WIDTH-1){1'b0}}, sub_i};
        sum_o = a_i + b_eff + cin;
        // Overflow when the effective addends share a sign and the sum does not.
        // For subtract, b_eff carries the inverted sign of b, so this becomes
        // "operand signs differ and result sign differs from a".
        ovf_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   32-bit integer ALU for the single-cycle MIPS execute stage. Produces a
//   combinational result/zero/overflow for same-cycle use, plus a registered
//   copy (one clk of latency) for a pipelined consumer. There is no
//   handshake: new operands are accepted every cycle and the registered
//   outputs simply follow the combinational ones one edge later.
//   Ports:
//     clk         in  1      rising-edge clock
//     reset       in  1      async active-high; clears *_q outputs only
//     var1        in  WIDTH  operand A (rs)
//     var2        in  WIDTH  operand B (rt or sign-extended immediate)
//     aluControl  in  4      operation select (alu_pkg codes)
//     aluout      out WIDTH  combinational result
//     zero        out 1      1 iff aluout == 0
//     overflow    out 1      signed overflow, ADD/SUB only
//     aluout_q    out WIDTH  aluout registered
//     zero_q      out 1      zero registered
//     overflow_q  out 1      overflow registered
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] var1,
    input  logic [WIDTH-1:0] var2,
    input  logic [3:0]       aluControl,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] aluout_q,
    output logic             zero_q,
    output logic             overflow_q
);

    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic             slt_bit;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i   (var1),
        .b_i   (var2),
        .sub_i (is_subtract(aluControl)),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    // Sign of (var1 - var2) corrected by overflow gives a signed less-than that
    // holds across the sign boundary.
    assign slt_bit = sum[WIDTH-1] ^ sum_ovf;

    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (aluControl)
            ALU_AND: aluout = var1 & var2;
            ALU_OR:  aluout = var1 | var2;
            ALU_ADD: begin
                aluout   = sum;
                overflow = sum_ovf;
            end
            ALU_SUB: begin
                aluout   = sum;
                overflow = sum_ovf;
            end
            ALU_SLT: aluout = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_NOR: aluout = ~(var1 | var2);
            default: begin
                aluout   = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = ~|aluout;

    // Output register bank.
    logic [WIDTH-1:0] aluout_d;
    logic             zero_d;
    logic             overflow_d;

    assign aluout_d   = aluout;
    assign zero_d     = zero;
    assign overflow_d = overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluout_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            aluout_q   <= aluout_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu: directed vectors with literal expectations,
//   randomized vectors against an arithmetic reference model, and a queue of
//   expected registered values checked one edge after each operation.
// -----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] var1, var2;
    logic [3:0]   aluControl;
    logic [W-1:0] aluout, aluout_q;
    logic         zero, overflow, zero_q, overflow_q;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .var1       (var1),
        .var2       (var2),
        .aluControl (aluControl),
        .aluout     (aluout),
        .zero       (zero),
        .overflow   (overflow),
        .aluout_q   (aluout_q),
        .zero_q     (zero_q),
        .overflow_q (overflow_q)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W+1:0] exp_q[$];   // {overflow, zero, result}

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model straight from the operation table, using wide signed math.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        o  = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin s = sa + sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: begin r = '0; o = 1'b0; end
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_res, input logic e_ovf);
        logic [W+1:0] e;
        @(negedge clk);
        aluControl = op;
        var1       = a;
        var2       = b;
        #1;
        check({tag, "_res"}, aluout, e_res);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, (e_res == '0)});
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, e_ovf});
        exp_q.push_back({e_ovf, (e_res == '0), e_res});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_res_q"}, aluout_q, e[W-1:0]);
        check({tag, "_zero_q"}, {31'b0, zero_q}, {31'b0, e[W]});
        check({tag, "_ovf_q"}, {31'b0, overflow_q}, {31'b0, e[W+1]});
    endtask

    task automatic mid_cycle_reset(input string tag, input logic [W-1:0] e_res);
        // Called at posedge+1; assert reset well before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_rst_res_q"}, aluout_q, '0);
        check({tag, "_rst_zero_q"}, {31'b0, zero_q}, 32'd0);
        check({tag, "_rst_ovf_q"}, {31'b0, overflow_q}, 32'd0);
        check({tag, "_rst_res_comb"}, aluout, e_res);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a, b, r;
        logic         o;
        logic [3:0]   op;
        logic [3:0]   legal[6];
        logic [W-1:0] corner[6];
        legal  = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        corner = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

        // Reset state: registered outputs held at 0 across an edge while the
        // combinational result is nonzero.
        reset      = 1'b1;
        aluControl = ALU_ADD;
        var1       = 32'd5;
        var2       = 32'd6;
        @(posedge clk);
        #1;
        check("reset_res_q", aluout_q, '0);
        check("reset_zero_q", {31'b0, zero_q}, 32'd0);
        check("reset_ovf_q", {31'b0, overflow_q}, 32'd0);
        check("reset_comb", aluout, 32'd11);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with literal expectations.
        run_op("and",      ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0);
        run_op("or",       ALU_OR,  32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0);
        run_op("add",      ALU_ADD, 32'd100,      32'd50,       32'd150,      1'b0);
        run_op("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1);
        run_op("add_novf", ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0);
        run_op("sub",      ALU_SUB, 32'd200,      32'd100,      32'd100,      1'b0);
        run_op("sub_zero", ALU_SUB, 32'd100,      32'd100,      32'd0,        1'b0);
        run_op("sub_ovf",  ALU_SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1);
        run_op("slt_lt",   ALU_SLT, 32'd10,       32'd20,       32'd1,        1'b0);
        run_op("slt_gt",   ALU_SLT, 32'd30,       32'd20,       32'd0,        1'b0);
        run_op("slt_neg",  ALU_SLT, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0);
        run_op("slt_bnd",  ALU_SLT, 32'h80000000, 32'd1,        32'd1,        1'b0);
        run_op("slt_bnd2", ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0);
        run_op("nor",      ALU_NOR, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0);
        run_op("bad_op",   4'b1111, 32'd123,      32'd456,      32'd0,        1'b0);

        // Registered path and asynchronous reset between edges.
        run_op("add12", ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0);
        mid_cycle_reset("add12", 32'd3);
        run_op("add_ovf2", ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
        mid_cycle_reset("add_ovf2", 32'h80000000);
        run_op("resume", ALU_SUB, 32'd7, 32'd9, 32'hFFFFFFFE, 1'b0);

        // Randomized vectors against the reference model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) < 6) op = legal[$urandom_range(0, 5)];
            else                          op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 9) == 0) b = a;
            model(op, a, b, r, o);
            run_op("rnd", op, a, b, r, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
